reorder_buffer: RTL and testbench

- Circular 16-entry reorder buffer. It allocates the ROB index that tags each decoded instruction in the reservation station and load/store buffer.
- It consumes the CDB broadcasts produced by the RS (ALU) and LSB, and retires results in program order to the register file.
- It detects branch mispredictions at commit and issues a pipeline flush.
- It answers operand-ready queries from dispatch so that new RS entries can capture already-finished values.

---
 rtl/reorder_buffer_pkg.sv | 27 ++
 rtl/reorder_buffer_if.sv | 58 +++++
 rtl/reorder_buffer_query_port.sv | 40 ++++
 rtl/reorder_buffer.sv | 186 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizes for the reorder buffer and its producers (RS, LSB).
package reorder_buffer_pkg;

    localparam int ROB_IDX_W = 4;
    localparam int ROB_DEPTH = 1 << ROB_IDX_W;
    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;
    localparam int CNT_W     = ROB_IDX_W + 1;

    typedef logic [ROB_IDX_W-1:0] rob_idx_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      word_t;
    typedef logic [CNT_W-1:0]     rob_cnt_t;

    // One result broadcast as seen by the ROB; shared by the RS and LSB buses.
    typedef struct packed {
        logic     valid;
        rob_idx_t pos;
        word_t    val;
    } cdb_t;

    // Where fetch must resume after a mispredicted branch retires.
    function automatic word_t redirect_pc(input logic taken, input word_t target, input word_t pc);
        return taken ? target : pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB, operand-query and retire signals of the reorder buffer.
// slave = the ROB itself, master = the surrounding pipeline.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic     alloc_valid;
    reg_idx_t alloc_rd;
    logic     alloc_is_branch;
    logic     alloc_pred_taken;
    word_t    alloc_pc;
    rob_idx_t alloc_pos;
    logic     rob_full;

    logic     cdb_rs_valid;
    rob_idx_t cdb_rs_rob_pos;
    word_t    cdb_rs_val;
    logic     cdb_rs_taken;
    word_t    cdb_rs_target;

    logic     cdb_lsb_valid;
    rob_idx_t cdb_lsb_rob_pos;
    word_t    cdb_lsb_val;

    rob_idx_t query1_pos;
    rob_idx_t query2_pos;
    logic     query1_ready;
    logic     query2_ready;
    word_t    query1_val;
    word_t    query2_val;

    logic     commit_valid;
    reg_idx_t commit_rd;
    word_t    commit_val;
    rob_idx_t commit_rob_pos;
    logic     flush;
    word_t    flush_pc;

    modport slave (
        input  alloc_valid, alloc_rd, alloc_is_branch, alloc_pred_taken, alloc_pc,
        output alloc_pos, rob_full,
        input  cdb_rs_valid, cdb_rs_rob_pos, cdb_rs_val, cdb_rs_taken, cdb_rs_target,
        input  cdb_lsb_valid, cdb_lsb_rob_pos, cdb_lsb_val,
        input  query1_pos, query2_pos,
        output query1_ready, query2_ready, query1_val, query2_val,
        output commit_valid, commit_rd, commit_val, commit_rob_pos, flush, flush_pc
    );

    modport master (
        output alloc_valid, alloc_rd, alloc_is_branch, alloc_pred_taken, alloc_pc,
        input  alloc_pos, rob_full,
        output cdb_rs_valid, cdb_rs_rob_pos, cdb_rs_val, cdb_rs_taken, cdb_rs_target,
        output cdb_lsb_valid, cdb_lsb_rob_pos, cdb_lsb_val,
        output query1_pos, query2_pos,
        input  query1_ready, query2_ready, query1_val, query2_val,
        input  commit_valid, commit_rd, commit_val, commit_rob_pos, flush, flush_pc
    );

endinterface

// File: rtl/reorder_buffer_query_port.sv
// Operand lookup for dispatch: a finished value comes either from the ROB
// entry itself or, in the cycle it is produced, straight off a CDB.
module reorder_buffer_query_port
    import reorder_buffer_pkg::*;
(
    input  rob_idx_t                        i_pos,
    input  logic [ROB_DEPTH-1:0]            i_busy,
    input  logic [ROB_DEPTH-1:0]            i_ready,
    input  logic [ROB_DEPTH-1:0][XLEN-1:0]  i_val,
    input  cdb_t                            i_cdb_rs,
    input  cdb_t                            i_cdb_lsb,
    output logic                            o_ready,
    output word_t                           o_val
);

    logic w_rs_hit;
    logic w_lsb_hit;
    logic w_stored_hit;

    assign w_rs_hit     = i_cdb_rs.valid  && (i_cdb_rs.pos  == i_pos);
    assign w_lsb_hit    = i_cdb_lsb.valid && (i_cdb_lsb.pos == i_pos);
    assign w_stored_hit = i_busy[i_pos] && i_ready[i_pos];

    // Bypass priority: RS broadcast, then LSB broadcast, then the stored value.
    always_comb begin
        o_ready = 1'b0;
        o_val   = '0;
        if (w_rs_hit) begin
            o_ready = 1'b1;
            o_val   = i_cdb_rs.val;
        end else if (w_lsb_hit) begin
            o_ready = 1'b1;
            o_val   = i_cdb_lsb.val;
        end else if (w_stored_hit) begin
            o_ready = 1'b1;
            o_val   = i_val[i_pos];
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: allocates tags at dispatch, collects CDB
// results, retires in program order and raises a flush on a mispredicted branch.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rdy,
    reorder_buffer_if.slave   io_rob
);

    rob_idx_t r_head;
    rob_idx_t r_tail;
    rob_cnt_t r_count;

    logic [ROB_DEPTH-1:0]           r_busy;
    logic [ROB_DEPTH-1:0]           r_ready;
    logic [ROB_DEPTH-1:0]           r_is_branch;
    logic [ROB_DEPTH-1:0]           r_pred;
    logic [ROB_DEPTH-1:0]           r_taken;
    logic [ROB_DEPTH-1:0][XLEN-1:0] r_val;
    reg_idx_t                       r_rd     [ROB_DEPTH];
    word_t                          r_target [ROB_DEPTH];
    word_t                          r_pc     [ROB_DEPTH];

    logic     r_commit_valid;
    reg_idx_t r_commit_rd;
    word_t    r_commit_val;
    rob_idx_t r_commit_rob_pos;
    logic     r_flush;
    word_t    r_flush_pc;

    logic w_full;
    logic w_alloc_acc;
    logic w_commit;
    logic w_mispredict;
    logic w_rs_wr;
    logic w_lsb_wr;
    cdb_t w_cdb_rs;
    cdb_t w_cdb_lsb;
    logic w_q1_ready;
    logic w_q2_ready;
    word_t w_q1_val;
    word_t w_q2_val;

    assign w_cdb_rs  = '{valid: io_rob.cdb_rs_valid,  pos: io_rob.cdb_rs_rob_pos,  val: io_rob.cdb_rs_val};
    assign w_cdb_lsb = '{valid: io_rob.cdb_lsb_valid, pos: io_rob.cdb_lsb_rob_pos, val: io_rob.cdb_lsb_val};

    // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot early.
    assign w_full       = (r_count == rob_cnt_t'(ROB_DEPTH));
    assign w_alloc_acc  = i_rdy && io_rob.alloc_valid && !w_full;
    assign w_commit     = i_rdy && (r_count != '0) && r_ready[r_head];
    assign w_mispredict = w_commit && r_is_branch[r_head] && (r_taken[r_head] != r_pred[r_head]);

    // Results aimed at idle entries are stale and dropped; RS wins a same-entry collision.
    assign w_rs_wr  = w_cdb_rs.valid && r_busy[w_cdb_rs.pos];
    assign w_lsb_wr = w_cdb_lsb.valid && r_busy[w_cdb_lsb.pos]
                      && !(w_cdb_rs.valid && (w_cdb_rs.pos == w_cdb_lsb.pos));

    // Head/tail pointers and occupancy; a flush empties the buffer and drops any allocate.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_rdy) begin
            if (w_mispredict) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_commit) begin
                    r_head <= r_head + 1'b1;
                end
                if (w_alloc_acc) begin
                    r_tail <= r_tail + 1'b1;
                end
                r_count <= r_count + rob_cnt_t'(w_alloc_acc) - rob_cnt_t'(w_commit);
            end
        end
    end

    // Per-entry state: CDB writeback, retire, flush and allocation, in that priority order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_ready <= '0;
        end else if (i_rdy) begin
            if (w_rs_wr) begin
                r_ready[w_cdb_rs.pos]  <= 1'b1;
                r_val[w_cdb_rs.pos]    <= w_cdb_rs.val;
                r_taken[w_cdb_rs.pos]  <= io_rob.cdb_rs_taken;
                r_target[w_cdb_rs.pos] <= io_rob.cdb_rs_target;
            end
            if (w_lsb_wr) begin
                r_ready[w_cdb_lsb.pos] <= 1'b1;
                r_val[w_cdb_lsb.pos]   <= w_cdb_lsb.val;
            end
            if (w_commit) begin
                r_busy[r_head]  <= 1'b0;
                r_ready[r_head] <= 1'b0;
            end
            if (w_mispredict) begin
                r_busy  <= '0;
                r_ready <= '0;
            end else if (w_alloc_acc) begin
                r_busy[r_tail]      <= 1'b1;
                r_ready[r_tail]     <= 1'b0;
                r_rd[r_tail]        <= io_rob.alloc_rd;
                r_is_branch[r_tail] <= io_rob.alloc_is_branch;
                r_pred[r_tail]      <= io_rob.alloc_pred_taken;
                r_pc[r_tail]        <= io_rob.alloc_pc;
                r_taken[r_tail]     <= 1'b0;
                r_target[r_tail]    <= '0;
                r_val[r_tail]       <= '0;
            end
        end
    end

    // Registered retire and redirect pulses; both forced low while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_valid   <= 1'b0;
            r_commit_rd      <= '0;
            r_commit_val     <= '0;
            r_commit_rob_pos <= '0;
            r_flush          <= 1'b0;
            r_flush_pc       <= '0;
        end else if (!i_rdy) begin
            r_commit_valid <= 1'b0;
            r_flush        <= 1'b0;
        end else begin
            r_commit_valid <= w_commit;
            r_flush        <= w_mispredict;
            if (w_commit) begin
                r_commit_rd      <= r_rd[r_head];
                r_commit_val     <= r_val[r_head];
                r_commit_rob_pos <= r_head;
            end
            if (w_mispredict) begin
                r_flush_pc <= redirect_pc(r_taken[r_head], r_target[r_head], r_pc[r_head]);
            end
        end
    end

    reorder_buffer_query_port u_query1 (
        .i_pos     (io_rob.query1_pos),
        .i_busy    (r_busy),
        .i_ready   (r_ready),
        .i_val     (r_val),
        .i_cdb_rs  (w_cdb_rs),
        .i_cdb_lsb (w_cdb_lsb),
        .o_ready   (w_q1_ready),
        .o_val     (w_q1_val)
    );

    reorder_buffer_query_port u_query2 (
        .i_pos     (io_rob.query2_pos),
        .i_busy    (r_busy),
        .i_ready   (r_ready),
        .i_val     (r_val),
        .i_cdb_rs  (w_cdb_rs),
        .i_cdb_lsb (w_cdb_lsb),
        .o_ready   (w_q2_ready),
        .o_val     (w_q2_val)
    );

    assign io_rob.alloc_pos      = r_tail;
    assign io_rob.rob_full       = w_full;
    assign io_rob.query1_ready   = w_q1_ready;
    assign io_rob.query1_val     = w_q1_val;
    assign io_rob.query2_ready   = w_q2_ready;
    assign io_rob.query2_val     = w_q2_val;
    assign io_rob.commit_valid   = r_commit_valid;
    assign io_rob.commit_rd      = r_commit_rd;
    assign io_rob.commit_val     = r_commit_val;
    assign io_rob.commit_rob_pos = r_commit_rob_pos;
    assign io_rob.flush          = r_flush;
    assign io_rob.flush_pc       = r_flush_pc;

    // Two result buses naming the same entry in one cycle is a producer bug.
    a_cdb_same_pos: assert property (@(posedge clk) disable iff (rst)
        !(io_rob.cdb_rs_valid && io_rob.cdb_lsb_valid
          && (io_rob.cdb_rs_rob_pos == io_rob.cdb_lsb_rob_pos)));

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed scenarios followed by a randomized run, all checked every cycle
// against a queue-based program-order model of the buffer.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    reorder_buffer_if ob();

    reorder_buffer dut (
        .clk    (clk),
        .rst    (rst),
        .i_rdy  (rdy),
        .io_rob (ob)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          pos;
        logic [4:0]  rd;
        bit          ready;
        logic [31:0] val;
        bit          br;
        bit          pred;
        bit          taken;
        logic [31:0] target;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    int   m_tail;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ob.alloc_valid      = 1'b0;
        ob.alloc_rd         = '0;
        ob.alloc_is_branch  = 1'b0;
        ob.alloc_pred_taken = 1'b0;
        ob.alloc_pc         = '0;
        ob.cdb_rs_valid     = 1'b0;
        ob.cdb_rs_rob_pos   = '0;
        ob.cdb_rs_val       = '0;
        ob.cdb_rs_taken     = 1'b0;
        ob.cdb_rs_target    = '0;
        ob.cdb_lsb_valid    = 1'b0;
        ob.cdb_lsb_rob_pos  = '0;
        ob.cdb_lsb_val      = '0;
        ob.query1_pos       = '0;
        ob.query2_pos       = '0;
    endtask

    // Operand is available if the in-flight instruction finished, or finishes on a bus now.
    task automatic model_query(input logic [3:0] pos, output logic r_o, output logic [31:0] v_o);
        r_o = 1'b0;
        v_o = '0;
        foreach (q[i]) begin
            if (q[i].pos == int'(pos) && q[i].ready) begin
                r_o = 1'b1;
                v_o = q[i].val;
            end
        end
        if (ob.cdb_lsb_valid && ob.cdb_lsb_rob_pos == pos) begin
            r_o = 1'b1;
            v_o = ob.cdb_lsb_val;
        end
        if (ob.cdb_rs_valid && ob.cdb_rs_rob_pos == pos) begin
            r_o = 1'b1;
            v_o = ob.cdb_rs_val;
        end
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle();
        logic        qr;
        logic [31:0] qv;
        bit          exp_cv;
        bit          exp_fl;
        bit          was_rst;
        ent_t        ce;
        ent_t        ne;
        logic [31:0] exp_fpc;
        exp_cv  = 0;
        exp_fl  = 0;
        exp_fpc = '0;
        was_rst = (rst === 1'b1);
        #1;
        check("rob_full", 32'(ob.rob_full), 32'(q.size() == ROB_DEPTH));
        check("alloc_pos", 32'(ob.alloc_pos), m_tail);
        model_query(ob.query1_pos, qr, qv);
        check("query1_ready", 32'(ob.query1_ready), 32'(qr));
        check("query1_val", ob.query1_val, qv);
        model_query(ob.query2_pos, qr, qv);
        check("query2_ready", 32'(ob.query2_ready), 32'(qr));
        check("query2_val", ob.query2_val, qv);
        if (was_rst) begin
            q.delete();
            m_tail = 0;
        end else if (rdy) begin
            if (q.size() > 0 && q[0].ready) begin
                exp_cv = 1;
                ce     = q[0];
                if (ce.br && ce.taken != ce.pred) begin
                    exp_fl  = 1;
                    exp_fpc = ce.taken ? ce.target : ce.pc + 32'd4;
                end
            end
            foreach (q[i]) begin
                if (ob.cdb_rs_valid && q[i].pos == int'(ob.cdb_rs_rob_pos)) begin
                    q[i].ready  = 1;
                    q[i].val    = ob.cdb_rs_val;
                    q[i].taken  = ob.cdb_rs_taken;
                    q[i].target = ob.cdb_rs_target;
                end else if (ob.cdb_lsb_valid && q[i].pos == int'(ob.cdb_lsb_rob_pos)) begin
                    q[i].ready = 1;
                    q[i].val   = ob.cdb_lsb_val;
                end
            end
            if (exp_cv) void'(q.pop_front());
            if (exp_fl) begin
                q.delete();
                m_tail = 0;
            end else if (ob.alloc_valid && (q.size() + (exp_cv ? 1 : 0)) < ROB_DEPTH) begin
                ne        = '{pos: m_tail, rd: ob.alloc_rd, ready: 0, val: '0, br: ob.alloc_is_branch,
                              pred: ob.alloc_pred_taken, taken: 0, target: '0, pc: ob.alloc_pc};
                q.push_back(ne);
                m_tail = (m_tail + 1) % ROB_DEPTH;
            end
        end
        @(posedge clk);
        #1;
        check("commit_valid", 32'(ob.commit_valid), 32'(exp_cv));
        check("flush", 32'(ob.flush), 32'(exp_fl));
        if (exp_cv) begin
            check("commit_rd", 32'(ob.commit_rd), 32'(ce.rd));
            check("commit_val", ob.commit_val, ce.val);
            check("commit_rob_pos", 32'(ob.commit_rob_pos), ce.pos);
        end
        if (exp_fl) check("flush_pc", ob.flush_pc, exp_fpc);
        if (was_rst) begin
            check("rst_commit_rd", 32'(ob.commit_rd), 0);
            check("rst_commit_val", ob.commit_val, 0);
            check("rst_commit_rob_pos", 32'(ob.commit_rob_pos), 0);
            check("rst_flush_pc", ob.flush_pc, 0);
        end
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        rdy = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        bit          seen;
        int          pend[$];
        int          rs_p;
        logic [31:0] tmp;
        m_tail = 0;
        idle();
        rst = 1'b1;
        rdy = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check("reset_commit_valid", 32'(ob.commit_valid), 0);
        check("reset_flush", 32'(ob.flush), 0);
        check("reset_rob_full", 32'(ob.rob_full), 0);
        check("reset_alloc_pos", 32'(ob.alloc_pos), 0);

        // First allocate, broadcast, commit two cycles after the broadcast edge.
        ob.alloc_valid = 1'b1;
        ob.alloc_rd    = 5'd5;
        ob.alloc_pc    = 32'h1000;
        cycle();
        idle();
        ob.cdb_rs_valid   = 1'b1;
        ob.cdb_rs_rob_pos = 4'd0;
        ob.cdb_rs_val     = 32'h1234;
        cycle();
        check("first_no_early_commit", 32'(ob.commit_valid), 0);
        idle();
        cycle();
        check("first_commit_valid", 32'(ob.commit_valid), 1);
        check("first_commit_rd", 32'(ob.commit_rd), 5);
        check("first_commit_val", ob.commit_val, 32'h1234);
        check("first_commit_pos", 32'(ob.commit_rob_pos), 0);
        cycle();
        check("first_pulse_ends", 32'(ob.commit_valid), 0);

        // Out-of-order completion retires in order.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ob.alloc_valid = 1'b1;
            ob.alloc_rd    = 5'(10 + i);
            cycle();
        end
        for (int i = 2; i >= 0; i--) begin
            idle();
            ob.cdb_rs_valid   = 1'b1;
            ob.cdb_rs_rob_pos = 4'(i);
            ob.cdb_rs_val     = 32'hA0 + 32'(i);
            cycle();
            check("ooo_no_commit_yet", 32'(ob.commit_valid), 0);
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("ooo_commit_valid", 32'(ob.commit_valid), 1);
            check("ooo_commit_order", 32'(ob.commit_rob_pos), i);
        end

        // Fill, refuse while full (even with a same-cycle pop), then wrap.
        do_reset();
        for (int i = 0; i < ROB_DEPTH; i++) begin
            ob.alloc_valid = 1'b1;
            ob.alloc_rd    = 5'(i);
            cycle();
        end
        check("full_flag", 32'(ob.rob_full), 1);
        check("full_tail_wrapped", 32'(ob.alloc_pos), 0);
        cycle();
        check("full_17th_ignored", 32'(ob.alloc_pos), 0);
        idle();
        ob.cdb_rs_valid   = 1'b1;
        ob.cdb_rs_rob_pos = 4'd0;
        ob.cdb_rs_val     = 32'd77;
        cycle();
        idle();
        ob.alloc_valid = 1'b1;
        cycle();
        check("full_pop_commit", 32'(ob.commit_valid), 1);
        check("full_alloc_refused", 32'(ob.alloc_pos), 0);
        check("full_after_pop", 32'(ob.rob_full), 0);
        cycle();
        check("wrap_alloc_accepted", 32'(ob.alloc_pos), 1);
        check("wrap_full_again", 32'(ob.rob_full), 1);

        // Mispredicted branch at pos 3 with younger entries 4..6.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            idle();
            ob.alloc_valid      = 1'b1;
            ob.alloc_rd         = 5'(i + 1);
            ob.alloc_is_branch  = (i == 3);
            ob.alloc_pred_taken = 1'b0;
            ob.alloc_pc         = 32'h100 + 32'(4 * i);
            cycle();
        end
        idle();
        ob.cdb_rs_valid   = 1'b1; ob.cdb_rs_rob_pos = 4'd3; ob.cdb_rs_val = 32'h55;
        ob.cdb_rs_taken   = 1'b1; ob.cdb_rs_target  = 32'h200;
        ob.cdb_lsb_valid  = 1'b1; ob.cdb_lsb_rob_pos = 4'd4; ob.cdb_lsb_val = 32'h4;
        cycle();
        for (int i = 0; i < 3; i++) begin
            idle();
            ob.cdb_rs_valid   = 1'b1; ob.cdb_rs_rob_pos = 4'(i); ob.cdb_rs_val = 32'(i);
            if (i < 2) begin
                ob.cdb_lsb_valid = 1'b1; ob.cdb_lsb_rob_pos = 4'(5 + i); ob.cdb_lsb_val = 32'(5 + i);
            end
            cycle();
        end
        idle();
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (ob.flush === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check("mis_flush_seen", 32'(seen), 1);
        check("mis_flush_pc", ob.flush_pc, 32'h200);
        check("mis_branch_commits", 32'(ob.commit_valid), 1);
        check("mis_branch_pos", 32'(ob.commit_rob_pos), 3);
        check("mis_branch_val", ob.commit_val, 32'h55);
        check("mis_tail_zero", 32'(ob.alloc_pos), 0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("mis_younger_dropped", 32'(ob.commit_valid), 0);
        end

        // Query bypass from the LSB bus, and a miss.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            ob.alloc_valid = 1'b1;
            cycle();
        end
        idle();
        ob.query1_pos      = 4'd7;
        ob.cdb_lsb_valid   = 1'b1;
        ob.cdb_lsb_rob_pos = 4'd7;
        ob.cdb_lsb_val     = 32'hAB;
        #1;
        check("bypass_ready", 32'(ob.query1_ready), 1);
        check("bypass_val", ob.query1_val, 32'hAB);
        cycle();
        idle();
        ob.query1_pos = 4'd8;
        ob.query2_pos = 4'd7;
        #1;
        check("miss_ready", 32'(ob.query1_ready), 0);
        check("miss_val", ob.query1_val, 0);
        check("stored_ready", 32'(ob.query2_ready), 1);
        check("stored_val", ob.query2_val, 32'hAB);
        cycle();

        // rdy stall with a ready head.
        idle();
        ob.cdb_rs_valid   = 1'b1;
        ob.cdb_rs_rob_pos = 4'd0;
        ob.cdb_rs_val     = 32'hC0;
        cycle();
        idle();
        rdy            = 1'b0;
        ob.alloc_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_no_commit", 32'(ob.commit_valid), 0);
            check("stall_tail_frozen", 32'(ob.alloc_pos), 8);
        end
        rdy = 1'b1;
        idle();
        cycle();
        check("resume_commit", 32'(ob.commit_valid), 1);
        check("resume_commit_pos", 32'(ob.commit_rob_pos), 0);
        check("resume_commit_val", ob.commit_val, 32'hC0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            idle();
            rst = ($urandom_range(0, 149) == 0);
            rdy = ($urandom_range(0, 7) != 0);
            ob.alloc_valid      = ($urandom_range(0, 3) != 0);
            ob.alloc_rd         = 5'($urandom);
            ob.alloc_is_branch  = ($urandom_range(0, 4) == 0);
            ob.alloc_pred_taken = 1'($urandom);
            tmp                 = $urandom;
            ob.alloc_pc         = tmp & 32'hFFFF_FFFC;
            pend.delete();
            foreach (q[i]) if (!q[i].ready) pend.push_back(q[i].pos);
            rs_p = -1;
            if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                rs_p = pend[$urandom_range(0, pend.size() - 1)];
            end else if ($urandom_range(0, 9) == 0) begin
                rs_p = $urandom_range(0, ROB_DEPTH - 1);
            end
            if (rs_p >= 0) begin
                ob.cdb_rs_valid   = 1'b1;
                ob.cdb_rs_rob_pos = 4'(rs_p);
                ob.cdb_rs_val     = $urandom;
                ob.cdb_rs_taken   = 1'($urandom);
                ob.cdb_rs_target  = $urandom & 32'hFFFF_FFFC;
            end
            if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
                int lp;
                lp = pend[$urandom_range(0, pend.size() - 1)];
                if (lp != rs_p) begin
                    ob.cdb_lsb_valid   = 1'b1;
                    ob.cdb_lsb_rob_pos = 4'(lp);
                    ob.cdb_lsb_val     = $urandom;
                end
            end
            ob.query1_pos = 4'($urandom_range(0, ROB_DEPTH - 1));
            ob.query2_pos = 4'($urandom_range(0, ROB_DEPTH - 1));
            cycle();
        end
        rst = 1'b0;
        rdy = 1'b1;
        idle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
